// File: rtl/sw_pkg.sv
// Status-word bit layout and writer FSM encoding, shared by the SW register,
// the flag writer and the branch unit.
package sw_pkg;
  localparam int SW_W     = 2;
  localparam int SW_Z_BIT = 0;
  localparam int SW_N_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    WRITE = 2'd2,
    CHECK = 2'd3
  } sw_wr_state_t;
endpackage

// File: rtl/sw_flag_calc.sv
// Derives N/Z from a result and merges them into the current SW under a
// per-flag mask; purely combinational so the branch unit can reuse it.
module sw_flag_calc
  import sw_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_res,
  input  logic [SW_W-1:0]   i_mask,
  input  logic [SW_W-1:0]   i_sw_q,
  output logic [SW_W-1:0]   o_sw_new,
  output logic              o_any_upd
);
  logic [SW_W-1:0] w_flag;

  always_comb begin
    w_flag           = '0;
    w_flag[SW_N_BIT] = i_res[DATA_W-1];
    w_flag[SW_Z_BIT] = (i_res == '0);
  end

  assign o_sw_new  = (i_mask & w_flag) | (~i_mask & i_sw_q);
  assign o_any_upd = |i_mask;
endmodule

// File: rtl/sw_flag_writer.sv
// Writer-side controller for the 2-bit status word. Define SW_READBACK_CHECK_EN
// to add the read-back CHECK state and the sticky err_o.
module sw_flag_writer
  import sw_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [DATA_W-1:0] res_i,
  input  logic [1:0]        upd_mask_i,
  input  logic [1:0]        sw_q_i,
  output logic              sw_wen_o,
  output logic [1:0]        sw_d_o,
  input  logic              clr_err_i,
  output logic              err_o,
  output logic [7:0]        upd_cnt_o
);
  sw_wr_state_t      r_state, w_next;
  logic [DATA_W-1:0] r_res;
  logic [SW_W-1:0]   r_mask;
  logic [SW_W-1:0]   r_sw_d;
  logic [7:0]        r_cnt;
  logic [SW_W-1:0]   w_sw_new;
  logic              w_any_upd;

  sw_flag_calc #(.DATA_W(DATA_W)) u_calc (
    .i_res     (r_res),
    .i_mask    (r_mask),
    .i_sw_q    (sw_q_i),
    .o_sw_new  (w_sw_new),
    .o_any_upd (w_any_upd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (res_valid_i) w_next = EVAL;
      EVAL:  w_next = w_any_upd ? WRITE : IDLE;
`ifdef SW_READBACK_CHECK_EN
      WRITE: w_next = CHECK;
`else
      WRITE: w_next = IDLE;
`endif
      CHECK: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // sw_d only changes when a write will follow, so it always holds the last written word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res  <= '0;
      r_mask <= '0;
      r_sw_d <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == IDLE && res_valid_i) begin
        r_res  <= res_i;
        r_mask <= upd_mask_i;
      end
      if (r_state == EVAL && w_any_upd) r_sw_d <= w_sw_new;
      if (r_state == WRITE)             r_cnt  <= r_cnt + 8'd1;
    end
  end

`ifdef SW_READBACK_CHECK_EN
  logic r_err;

  // a fresh mismatch outranks a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  r_err <= 1'b0;
    else if (r_state == CHECK && sw_q_i != r_sw_d) r_err <= 1'b1;
    else if (clr_err_i)                           r_err <= 1'b0;
  end

  assign err_o = r_err;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_err_i;
  assign err_o        = 1'b0;
`endif

  assign res_ready_o = (r_state == IDLE);
  assign sw_wen_o    = (r_state == WRITE);
  assign sw_d_o      = r_sw_d;
  assign upd_cnt_o   = r_cnt;
endmodule

// File: tb/tb_sw_flag_writer.sv
// Directed bench for sw_flag_writer with a behavioural SW register and an
// optional stuck read-back to provoke mismatches.
module tb_sw_flag_writer;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       res_valid_i;
  logic       res_ready_o;
  logic [7:0] res_i;
  logic [1:0] upd_mask_i;
  logic [1:0] sw_q_i;
  logic       sw_wen_o;
  logic [1:0] sw_d_o;
  logic       clr_err_i;
  logic       err_o;
  logic [7:0] upd_cnt_o;

  logic [1:0] r_swreg;
  logic       fault_en;
  logic [1:0] fault_val;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_cnt = 0;

  sw_flag_writer #(.DATA_W(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_i       (res_i),
    .upd_mask_i  (upd_mask_i),
    .sw_q_i      (sw_q_i),
    .sw_wen_o    (sw_wen_o),
    .sw_d_o      (sw_d_o),
    .clr_err_i   (clr_err_i),
    .err_o       (err_o),
    .upd_cnt_o   (upd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_swreg <= 2'b00;
    else if (sw_wen_o) r_swreg <= sw_d_o;
  end

  assign sw_q_i = fault_en ? fault_val : r_swreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one result from IDLE and follow it back to IDLE, checking each cycle.
  task automatic txn(input string tag, input logic [7:0] r, input logic [1:0] m,
                     input logic [1:0] exp_d);
    chk({tag, "_rdy0"}, res_ready_o, 1);
    res_valid_i = 1'b1; res_i = r; upd_mask_i = m;
    @(negedge clk_i);
    res_valid_i = 1'b0; res_i = 8'hAA; upd_mask_i = 2'b11;
    chk({tag, "_eval_rdy"}, res_ready_o, 0);
    chk({tag, "_eval_wen"}, sw_wen_o, 0);
    @(negedge clk_i);
    if (m != 2'b00) begin
      exp_cnt = (exp_cnt + 1) % 256;
      chk({tag, "_wen"}, sw_wen_o, 1);
      chk({tag, "_d"}, sw_d_o, exp_d);
      chk({tag, "_wr_rdy"}, res_ready_o, 0);
      @(negedge clk_i);
      chk({tag, "_wen_off"}, sw_wen_o, 0);
      chk({tag, "_cnt"}, upd_cnt_o, exp_cnt);
`ifdef SW_READBACK_CHECK_EN
      chk({tag, "_chk_rdy"}, res_ready_o, 0);
      @(negedge clk_i);
`endif
      chk({tag, "_d_hold"}, sw_d_o, exp_d);
    end else begin
      chk({tag, "_nowen"}, sw_wen_o, 0);
      chk({tag, "_cnt_same"}, upd_cnt_o, exp_cnt);
      chk({tag, "_d_hold"}, sw_d_o, exp_d);
    end
    chk({tag, "_rdy_back"}, res_ready_o, 1);
  endtask

  initial begin
    rst_ni = 1'b0; res_valid_i = 1'b0; res_i = '0; upd_mask_i = '0;
    clr_err_i = 1'b0; fault_en = 1'b0; fault_val = 2'b00;
    #1;
    chk("rst_rdy", res_ready_o, 1);
    chk("rst_wen", sw_wen_o, 0);
    chk("rst_d", sw_d_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", upd_cnt_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rel_rdy", res_ready_o, 1);

    // 00 -> N set only gives 10; then zero result with full mask gives 01
    txn("preload", 8'h80, 2'b10, 2'b10);
    txn("zero", 8'h00, 2'b11, 2'b01);
    chk("zero_err", err_o, 0);
    txn("neg_part", 8'h80, 2'b10, 2'b11);
    txn("mask00", 8'h05, 2'b00, 2'b11);
    txn("pos_full", 8'h7F, 2'b11, 2'b00);
    txn("zmask", 8'h00, 2'b01, 2'b01);
    txn("nmask_keepz", 8'hC3, 2'b10, 2'b11);

    // stuck read-back while 01 is written
    fault_en = 1'b1; fault_val = 2'b00;
    txn("flt1", 8'h00, 2'b11, 2'b01);
`ifdef SW_READBACK_CHECK_EN
    chk("flt_err_set", err_o, 1);
    @(negedge clk_i);
    chk("flt_err_held", err_o, 1);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    chk("flt_err_clr", err_o, 0);
    clr_err_i = 1'b1;
    txn("flt2", 8'h00, 2'b11, 2'b01);
    chk("flt_set_wins", err_o, 1);
    clr_err_i = 1'b0;
    fault_en = 1'b0;
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    chk("flt_final_clr", err_o, 0);
`else
    chk("flt_err_tied", err_o, 0);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    chk("flt_err_tied2", err_o, 0);
    fault_en = 1'b0;
`endif

    // asynchronous reset in the middle of WRITE
    res_valid_i = 1'b1; res_i = 8'h80; upd_mask_i = 2'b11;
    @(negedge clk_i);
    res_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_wen_pre", sw_wen_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_wen_drop", sw_wen_o, 0);
    chk("mid_rdy", res_ready_o, 1);
    chk("mid_cnt", upd_cnt_o, 0);
    chk("mid_d", sw_d_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_cnt = 0;
    @(negedge clk_i);
    chk("post_rst_rdy", res_ready_o, 1);
    chk("post_rst_wen", sw_wen_o, 0);

    // 256 writes bring the counter back to zero
    for (int i = 0; i < 256; i++)
      txn("wrap", 8'(i), 2'b11, {i[7], (i == 0) ? 1'b1 : 1'b0});
    chk("wrap_cnt0", upd_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
